// File: rtl/riscv_formal_rvfi_serializer_pkg.sv
// Shared definitions for the RVFI serializer: field widths and entry layout.
// An entry is {post_trap, post_rd, post_pc, pre_rs2, pre_rs1, pre_pc, insn, rd, rs2, rs1}.
// Downstream checkers that unpack stored entries use the same offsets.
package riscv_formal_rvfi_serializer_pkg;

    localparam int REG_IDX_W = 5;
    localparam int INSN_W    = 32;

    localparam int RS1_LSB  = 0;
    localparam int RS2_LSB  = 5;
    localparam int RD_LSB   = 10;
    localparam int INSN_LSB = 15;
    localparam int XFLD_LSB = 47;   // first XLEN-wide field (pre_pc)

    // XLEN-wide field indices, in ascending bit order
    localparam int XF_PRE_PC   = 0;
    localparam int XF_PRE_RS1  = 1;
    localparam int XF_PRE_RS2  = 2;
    localparam int XF_POST_PC  = 3;
    localparam int XF_POST_RD  = 4;

    // Total entry width: three register indices, insn, five XLEN fields, trap bit
    function automatic int entry_width(input int xlen);
        return 3 * REG_IDX_W + INSN_W + 5 * xlen + 1;
    endfunction

    // LSB of the n-th XLEN-wide field
    function automatic int xfield_lsb(input int xlen, input int n);
        return XFLD_LSB + n * xlen;
    endfunction

    // LSB of the trap flag (topmost bit)
    function automatic int trap_lsb(input int xlen);
        return XFLD_LSB + 5 * xlen;
    endfunction

endpackage

// File: rtl/riscv_formal_rvfi_serializer_compactor.sv
// Packs each retirement channel into an entry and squeezes the valid ones,
// lowest channel first, into slots 0..k-1. Purely combinational.
module riscv_formal_rvfi_serializer_compactor
    import riscv_formal_rvfi_serializer_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NRET = 2,
    parameter int EW   = entry_width(XLEN),
    parameter int KW   = $clog2(NRET + 1)
) (
    input  logic [NRET-1:0]      valid,
    input  logic [NRET*5-1:0]    rs1,
    input  logic [NRET*5-1:0]    rs2,
    input  logic [NRET*5-1:0]    rd,
    input  logic [NRET*32-1:0]   insn,
    input  logic [NRET*XLEN-1:0] pre_pc,
    input  logic [NRET*XLEN-1:0] pre_rs1,
    input  logic [NRET*XLEN-1:0] pre_rs2,
    input  logic [NRET*XLEN-1:0] post_pc,
    input  logic [NRET*XLEN-1:0] post_rd,
    input  logic [NRET-1:0]      post_trap,
    output logic [NRET*EW-1:0]   slots,
    output logic [KW-1:0]        k
);

    // Place each valid channel's entry at the next free slot
    always_comb begin
        int idx;
        slots = '0;
        idx   = 0;
        for (int i = 0; i < NRET; i++) begin
            if (valid[i]) begin
                slots[idx*EW +: EW] = {post_trap[i],
                                       post_rd[i*XLEN +: XLEN],
                                       post_pc[i*XLEN +: XLEN],
                                       pre_rs2[i*XLEN +: XLEN],
                                       pre_rs1[i*XLEN +: XLEN],
                                       pre_pc[i*XLEN +: XLEN],
                                       insn[i*32 +: 32],
                                       rd[i*5 +: 5],
                                       rs2[i*5 +: 5],
                                       rs1[i*5 +: 5]};
                idx = idx + 1;
            end else begin
                idx = idx;
            end
        end
        k = KW'(idx);
    end

endmodule

// File: rtl/riscv_formal_rvfi_serializer.sv
// Serializes NRET-wide RVFI retirements into a single-channel stream.
// Compacted bundles enter a FIFO; the output register pops one per cycle.
// Bundles that would not fit are dropped whole and flagged by sticky overflow.
module riscv_formal_rvfi_serializer
    import riscv_formal_rvfi_serializer_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NRET    = 2,
    parameter int DEPTH   = 8,
    parameter int ORDER_W = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NRET-1:0]      rvfi_valid,
    input  logic [NRET*5-1:0]    rvfi_rs1,
    input  logic [NRET*5-1:0]    rvfi_rs2,
    input  logic [NRET*5-1:0]    rvfi_rd,
    input  logic [NRET*32-1:0]   rvfi_insn,
    input  logic [NRET*XLEN-1:0] rvfi_pre_pc,
    input  logic [NRET*XLEN-1:0] rvfi_pre_rs1,
    input  logic [NRET*XLEN-1:0] rvfi_pre_rs2,
    input  logic [NRET*XLEN-1:0] rvfi_post_pc,
    input  logic [NRET*XLEN-1:0] rvfi_post_rd,
    input  logic [NRET-1:0]      rvfi_post_trap,
    output logic                 out_valid,
    output logic [4:0]           out_rs1,
    output logic [4:0]           out_rs2,
    output logic [4:0]           out_rd,
    output logic [31:0]          out_insn,
    output logic [XLEN-1:0]      out_pre_pc,
    output logic [XLEN-1:0]      out_pre_rs1,
    output logic [XLEN-1:0]      out_pre_rs2,
    output logic [XLEN-1:0]      out_post_pc,
    output logic [XLEN-1:0]      out_post_rd,
    output logic                 out_post_trap,
    output logic [ORDER_W-1:0]   out_order,
    output logic                 overflow
);

    localparam int EW = entry_width(XLEN);
    localparam int KW = $clog2(NRET + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [NRET*EW-1:0] slots_s;
    logic [KW-1:0]      k_s;
    logic               pop_s;
    logic               accept_s;
    logic [CW:0]        sum_s;

    logic [EW-1:0]      mem_r [DEPTH];
    logic [PW-1:0]      wr_ptr_r;
    logic [PW-1:0]      rd_ptr_r;
    logic [CW-1:0]      count_r;
    logic [EW-1:0]      out_entry_r;
    logic               out_valid_r;
    logic [ORDER_W-1:0] out_order_r;
    logic               overflow_r;

    riscv_formal_rvfi_serializer_compactor #(
        .XLEN (XLEN),
        .NRET (NRET),
        .EW   (EW),
        .KW   (KW)
    ) u_compactor (
        .valid     (rvfi_valid),
        .rs1       (rvfi_rs1),
        .rs2       (rvfi_rs2),
        .rd        (rvfi_rd),
        .insn      (rvfi_insn),
        .pre_pc    (rvfi_pre_pc),
        .pre_rs1   (rvfi_pre_rs1),
        .pre_rs2   (rvfi_pre_rs2),
        .post_pc   (rvfi_post_pc),
        .post_rd   (rvfi_post_rd),
        .post_trap (rvfi_post_trap),
        .slots     (slots_s),
        .k         (k_s)
    );

    // Occupancy after this cycle decides whether the whole bundle fits
    always_comb begin
        pop_s    = (count_r != {CW{1'b0}});
        sum_s    = {1'b0, count_r} - (CW+1)'(pop_s) + (CW+1)'(k_s);
        accept_s = (sum_s <= (CW+1)'(DEPTH));
    end

    // FIFO storage: write the k compacted slots at consecutive wrapped addresses
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int d = 0; d < DEPTH; d++) begin
                mem_r[d] <= '0;
            end
        end else begin
            for (int j = 0; j < NRET; j++) begin
                if (accept_s && (j < int'(k_s))) begin
                    mem_r[wr_ptr_r + PW'(j)] <= slots_s[j*EW +: EW];
                end
            end
        end
    end

    // Pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(k_s);
                count_r  <= sum_s[CW-1:0];
            end else begin
                overflow_r <= 1'b1;
                count_r    <= count_r - CW'(pop_s);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
        end
    end

    // Output head stage: load FIFO head when available, otherwise hold data
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_entry_r <= '0;
            out_valid_r <= 1'b0;
            out_order_r <= '0;
        end else begin
            out_valid_r <= pop_s;
            if (pop_s) begin
                out_entry_r <= mem_r[rd_ptr_r];
            end
            if (out_valid_r) begin
                out_order_r <= out_order_r + ORDER_W'(1);
            end
        end
    end

    assign out_valid     = out_valid_r;
    assign out_order     = out_order_r;
    assign overflow      = overflow_r;
    assign out_rs1       = out_entry_r[RS1_LSB +: 5];
    assign out_rs2       = out_entry_r[RS2_LSB +: 5];
    assign out_rd        = out_entry_r[RD_LSB +: 5];
    assign out_insn      = out_entry_r[INSN_LSB +: 32];
    assign out_pre_pc    = out_entry_r[xfield_lsb(XLEN, XF_PRE_PC) +: XLEN];
    assign out_pre_rs1   = out_entry_r[xfield_lsb(XLEN, XF_PRE_RS1) +: XLEN];
    assign out_pre_rs2   = out_entry_r[xfield_lsb(XLEN, XF_PRE_RS2) +: XLEN];
    assign out_post_pc   = out_entry_r[xfield_lsb(XLEN, XF_POST_PC) +: XLEN];
    assign out_post_rd   = out_entry_r[xfield_lsb(XLEN, XF_POST_RD) +: XLEN];
    assign out_post_trap = out_entry_r[trap_lsb(XLEN)];

endmodule
